program_loader: RTL and testbench

- Boot-time loader sitting upstream of the core's program memory.
- Consumes a byte stream (UART receiver or debug port), assembles little-endian 32-bit instructions and writes them into program memory.
- Drives the memory's programming flag and holds the core in reset until a verified image is present.
- Provides the Harvard program-load path that the core currently has no driver for.

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_word_assembler.sv | 38 +++
 rtl/program_loader.sv | 112 +++++++++++
 tb/tb_program_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state type, defaults and helpers for the program loader
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which the inter-byte timeout runs.
  function automatic logic is_timed(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
  endfunction

  // States that listen for a new sync byte.
  function automatic logic is_rest(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - little-endian byte-to-word packer with running XOR checksum
module program_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [7:0]  checksum,
  output logic        last_byte,
  output logic        word_ready
);

  logic [1:0] idx;

  assign last_byte = (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      checksum   <= 8'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        idx      <= 2'd0;
        checksum <= 8'd0;
      end else if (byte_valid) begin
        word[8*idx +: 8] <= byte_data;
        checksum         <= checksum ^ byte_data;
        idx              <= idx + 2'd1;
        word_ready       <= (idx == 2'd3);
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte frames in, program memory writes and core reset control out
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_ADDR_WIDTH = 10,
  parameter int         TIMEOUT_CYCLES   = 1000000,
  parameter bit         BOOT_HOLD        = 1'b1,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        pm_we,
  output logic [INSTR_ADDR_WIDTH-1:0] pm_addr,
  output logic [31:0]                 pm_wdata,
  output logic                        pgm,
  output logic                        core_rst,
  output logic                        done,
  output logic                        err
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << INSTR_ADDR_WIDTH;

  state_t        state, state_next;
  logic [15:0]   count;
  logic [TW-1:0] timer;
  logic [7:0]    checksum;
  logic          last_byte;
  logic          xfer, sync_seen, timeout, last_word;
  logic [15:0]   len_n;

  assign xfer      = in_valid & in_ready;
  assign sync_seen = is_rest(state) && xfer && (in_data == SYNC_BYTE);
  assign timeout   = is_timed(state) && !xfer && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_word = (16'(pm_addr) == count - 16'd1);
  assign len_n     = {in_data, count[7:0]};

  program_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (sync_seen),
    .byte_valid (xfer && (state == S_DATA)),
    .byte_data  (in_data),
    .word       (pm_wdata),
    .checksum   (checksum),
    .last_byte  (last_byte),
    .word_ready (pm_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (sync_seen) state_next = S_LEN_LO;
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: if (xfer) state_next = ((len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS)) ? S_ERROR : S_DATA;
      S_DATA:   if (xfer && last_byte) state_next = S_WRITE;
      S_WRITE:  state_next = last_word ? S_CHECK : S_DATA;
      S_CHECK:  if (xfer) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
      default:  state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_ERROR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b1;
      pm_addr  <= '0;
      pgm      <= 1'b0;
      core_rst <= BOOT_HOLD;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= 16'd0;
      timer    <= '0;
    end else begin
      in_ready <= (state_next != S_WRITE);
      if (xfer || !is_timed(state)) timer <= '0;
      else                          timer <= timer + 1'b1;

      if (sync_seen) begin
        pm_addr  <= '0;
        pgm      <= 1'b1;
        core_rst <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end
      if (state == S_LEN_LO && xfer) count[7:0]  <= in_data;
      if (state == S_LEN_HI && xfer) count[15:8] <= in_data;
      // Hold on the final word so the address never wraps past the top of memory.
      if (state == S_WRITE && !last_word) pm_addr <= pm_addr + 1'b1;

      if (state_next == S_DONE && state != S_DONE) begin
        done     <= 1'b1;
        pgm      <= 1'b0;
        core_rst <= 1'b0;
      end
      if (state_next == S_ERROR && state != S_ERROR) begin
        err      <= 1'b1;
        pgm      <= 1'b0;
        core_rst <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed bench with a write-queue model for program_loader
module tb_program_loader;

  localparam int AW   = 2;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready, pm_we, pgm, core_rst, done, err;
  logic [AW-1:0] pm_addr;
  logic [31:0]   pm_wdata;
  logic          in_ready_b, pm_we_b, pgm_b, core_rst_b, done_b, err_b;
  logic [AW-1:0] pm_addr_b;
  logic [31:0]   pm_wdata_b;

  int vectors = 0;
  int miscompares = 0;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] words[$];

  always #5 clk = ~clk;

  program_loader #(.INSTR_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pgm(pgm),
    .core_rst(core_rst), .done(done), .err(err)
  );

  program_loader #(.INSTR_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .BOOT_HOLD(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .pm_we(pm_we_b), .pm_addr(pm_addr_b), .pm_wdata(pm_wdata_b), .pgm(pgm_b),
    .core_rst(core_rst_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every cycle: a write must match the head of the expected-write queue, ready is low only while writing.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("ready_not_we", {31'd0, in_ready}, {31'd0, ~pm_we});
      if ((done || err) && pgm) check("pgm_after_end", {31'd0, pgm}, 32'd0);
      if (pm_we) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write", {31'd0, pm_we}, 32'd0);
        end else begin
          check("write_addr", 32'(pm_addr), 32'(exp_addr[0]));
          check("write_data", pm_wdata, exp_data[0]);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
      end
    end
  end

  task automatic put_byte(input logic [7:0] b);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string tag, input bit good);
    check({tag, "_done"}, {31'd0, done}, {31'd0, good});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !good});
    check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, !good});
    check({tag, "_pgm"}, {31'd0, pgm}, 32'd0);
  endtask

  // Builds the frame from the words queue; the model expects every word at its index.
  task automatic run_frame(input string tag, input int n, input bit bad);
    logic [7:0] chk;
    logic [7:0] b;
    bit ok_len;
    chk = 8'd0;
    ok_len = (n >= 1) && (n <= MAXW);
    put_byte(8'hA5);
    check({tag, "_pgm_open"}, {31'd0, pgm}, 32'd1);
    check({tag, "_core_rst_open"}, {31'd0, core_rst}, 32'd1);
    put_byte(n[7:0]);
    put_byte(n[15:8]);
    if (ok_len) begin
      foreach (words[i]) begin
        exp_addr.push_back(i);
        exp_data.push_back(words[i]);
        for (int k = 0; k < 4; k++) begin
          b = words[i][8*k +: 8];
          chk = chk ^ b;
          put_byte(b);
        end
      end
      put_byte(bad ? (chk ^ 8'h01) : chk);
    end
    check_end(tag, ok_len && !bad);
  endtask

  logic [7:0] frame_a[12];
  int t_err;

  initial begin
    frame_a = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_core_rst_nohold", {31'd0, core_rst_b}, 32'd0);
    check("rst_pgm", {31'd0, pgm}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_pm_we", {31'd0, pm_we}, 32'd0);
    check("rst_pm_addr", 32'(pm_addr), 32'd0);
    check("rst_pm_wdata", pm_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Literal frame with hand-computed writes and checksum.
    exp_addr.push_back(0); exp_data.push_back(32'h00000013);
    exp_addr.push_back(1); exp_data.push_back(32'h00100093);
    for (int i = 0; i < 12; i++) begin
      put_byte(frame_a[i]);
      if (i == 0) check("nohold_core_rst_sync", {31'd0, core_rst_b}, 32'd1);
    end
    check_end("frame_a", 1'b1);
    check("nohold_core_rst_done", {31'd0, core_rst_b}, 32'd0);

    exp_addr.push_back(0); exp_data.push_back(32'h00000013);
    exp_addr.push_back(1); exp_data.push_back(32'h00100093);
    frame_a[11] = 8'h91;
    for (int i = 0; i < 12; i++) put_byte(frame_a[i]);
    check_end("frame_a_badchk", 1'b0);

    words = '{32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'hFFFFFFFF};
    run_frame("max_len", 4, 1'b0);
    words = '{32'hCAFE0001};
    run_frame("one_word_bad", 1, 1'b1);
    words = '{};
    run_frame("len_zero", 0, 1'b0);
    run_frame("len_five", 5, 1'b0);
    words = '{32'h0BADF00D, 32'h00C0FFEE};
    idle(3);
    run_frame("gap_good", 2, 1'b0);

    // Timeout: one full word plus two bytes, then silence.
    put_byte(8'hA5); put_byte(8'h02); put_byte(8'h00);
    exp_addr.push_back(0); exp_data.push_back(32'h44332211);
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
    put_byte(8'h55); put_byte(8'h66);
    in_valid = 1'b0;
    t_err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (err) begin
        t_err = k;
        break;
      end
    end
    check("timeout_cycles", 32'(t_err), 32'd16);
    check_end("timeout", 1'b0);

    // Asynchronous reset while the first word is being written.
    put_byte(8'hA5); put_byte(8'h03); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'h04);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_pm_we", {31'd0, pm_we}, 32'd0);
    check("arst_pm_addr", 32'(pm_addr), 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_pgm", {31'd0, pgm}, 32'd0);
    check("arst_core_rst", {31'd0, core_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    put_byte(8'h00); put_byte(8'h13); put_byte(8'hFF); put_byte(8'h02);
    check("garbage_pgm", {31'd0, pgm}, 32'd0);
    check("garbage_done", {31'd0, done}, 32'd0);
    words = '{32'h76543210, 32'h89ABCDEF, 32'h00000001};
    run_frame("after_reset", 3, 1'b0);

    idle(4);
    check("pending_writes", 32'(exp_addr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
